// File: rtl/pool_window_sched.sv
// Turns a raster stream into 2x2 max-pool windows (4 beats each, first/last flagged).
// Optional start-of-frame resync input enabled by defining POOL_SCHED_SOF_EN.
//
// state    | meaning
// FILL     | even row: store incoming pixels in the line buffer
// EMIT_BUF | odd row: present the buffered pixel above the current column
// WAIT_IN  | odd row: wait for the current-row pixel and present it
module pool_window_sched #(
  parameter int INPUT_NUM = 6,
  parameter int WDP       = 9,
  parameter int IMG_W     = 24,
  parameter int IMG_H     = 24
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WDP*INPUT_NUM-1:0] in_data,
`ifdef POOL_SCHED_SOF_EN
  input  logic                     sof,
`endif
  output logic                     q_en,
  output logic                     q_first,
  output logic                     q_last,
  output logic [WDP*INPUT_NUM-1:0] q,
  output logic                     frame_done
);

  localparam int DW = WDP * INPUT_NUM;
  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  if (IMG_W < 2 || (IMG_W % 2) != 0) begin : g_bad_img_w
    $error("pool_window_sched: IMG_W must be even and >= 2");
  end
  if (IMG_H < 2 || (IMG_H % 2) != 0) begin : g_bad_img_h
    $error("pool_window_sched: IMG_H must be even and >= 2");
  end

  typedef enum logic [1:0] {FILL, EMIT_BUF, WAIT_IN} state_t;

  state_t          state_q;
  logic [CW-1:0]   col_q;
  logic [RW-1:0]   row_q;
  logic            en_q, first_q, last_q, frame_done_q;
  logic [DW-1:0]   data_q;
  logic [DW-1:0]   line_q [IMG_W];
  logic            xfer, sof_hit;

  assign in_ready = (state_q == FILL) || (state_q == WAIT_IN);
  assign xfer     = in_valid & in_ready;

`ifdef POOL_SCHED_SOF_EN
  assign sof_hit = xfer & sof;
`else
  assign sof_hit = 1'b0;
`endif

  // Line buffer carries no reset; a resync pixel always lands in slot 0.
  always_ff @(posedge clk) begin
    if (xfer && (sof_hit || state_q == FILL))
      line_q[sof_hit ? '0 : col_q] <= in_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= FILL;
      col_q        <= '0;
      row_q        <= '0;
      en_q         <= 1'b0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      data_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (sof_hit) begin
        state_q <= FILL;
        col_q   <= CW'(1);
        row_q   <= '0;
        en_q    <= 1'b0;
        first_q <= 1'b0;
        last_q  <= 1'b0;
      end else begin
        case (state_q)
          FILL: begin
            en_q    <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            if (xfer) begin
              if (col_q == COL_LAST) begin
                col_q   <= '0;
                row_q   <= row_q + 1'b1;
                state_q <= EMIT_BUF;
              end else begin
                col_q <= col_q + 1'b1;
              end
            end
          end
          EMIT_BUF: begin
            data_q  <= line_q[col_q];
            en_q    <= 1'b1;
            first_q <= ~col_q[0];
            last_q  <= 1'b0;
            state_q <= WAIT_IN;
          end
          WAIT_IN: begin
            if (xfer) begin
              data_q  <= in_data;
              en_q    <= 1'b1;
              first_q <= 1'b0;
              last_q  <= col_q[0];
              if (col_q == COL_LAST) begin
                col_q   <= '0;
                state_q <= FILL;
                if (row_q == ROW_LAST) begin
                  row_q        <= '0;
                  frame_done_q <= 1'b1;
                end else begin
                  row_q <= row_q + 1'b1;
                end
              end else begin
                col_q   <= col_q + 1'b1;
                state_q <= EMIT_BUF;
              end
            end else begin
              en_q    <= 1'b0;
              first_q <= 1'b0;
              last_q  <= 1'b0;
            end
          end
          default: state_q <= FILL;
        endcase
      end
    end
  end

  assign q_en       = en_q;
  assign q_first    = first_q;
  assign q_last     = last_q;
  assign q          = data_q;
  assign frame_done = frame_done_q;

endmodule
